branch_issue_queue: RTL and testbench

- Parametrised out-of-order issue queue for branch and jump µops; next generation of the branch buffer.
- Sits between rename/dispatch and the branch resolution unit.
- Accepts dispatched branches, tracks operand readiness through WB_PORTS register-writeback wakeup buses, and issues one ready entry per cycle over a valid/ready handshake.
- Supports full pipeline flush and reports occupancy.

---
 rtl/branch_issue_queue.sv | 247 ++++++++++++++++++++++++
 tb/tb_branch_issue_queue.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_issue_queue.sv
// Out-of-order issue queue for branch/jump uops with writeback wakeup, hold-until-accept issue
// and flush. Define BIQ_AGE_SELECT_EN to issue the oldest ready entry instead of the lowest index.
module branch_issue_queue #(
  parameter int unsigned L        = 8,
  parameter int unsigned ROB_W    = 4,
  parameter int unsigned PC_W     = 16,
  parameter int unsigned DREG_W   = 3,
  parameter int unsigned SREG_W   = 2,
  parameter int unsigned WB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [ROB_W-1:0]           alloc_rob_addr,
  input  logic                       alloc_jump,
  input  logic                       alloc_predict_taken,
  input  logic [PC_W-1:0]            alloc_pc,
  input  logic [PC_W-1:0]            alloc_predict_target,
  input  logic [DREG_W-1:0]          alloc_rt_addr,
  input  logic                       alloc_rt_ready,
  input  logic [DREG_W-1:0]          alloc_rw_addr,
  input  logic [SREG_W-1:0]          alloc_rs_addr,
  input  logic                       alloc_rs_ready,
  input  logic [WB_PORTS-1:0]        wake_d_valid,
  input  logic [WB_PORTS*DREG_W-1:0] wake_d_addr,
  input  logic [WB_PORTS-1:0]        wake_s_valid,
  input  logic [WB_PORTS*SREG_W-1:0] wake_s_addr,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [ROB_W-1:0]           issue_rob_addr,
  output logic                       issue_jump,
  output logic                       issue_predict_taken,
  output logic [PC_W-1:0]            issue_pc,
  output logic [PC_W-1:0]            issue_predict_target,
  output logic [DREG_W-1:0]          issue_rt_addr,
  output logic [DREG_W-1:0]          issue_rw_addr,
  output logic [SREG_W-1:0]          issue_rs_addr,
  input  logic                       flush,
  output logic [$clog2(L):0]         count
);

  localparam int unsigned IdxW = $clog2(L);
  localparam int unsigned CntW = IdxW + 1;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic              jump;
    logic              taken;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   target;
    logic [DREG_W-1:0] rt;
    logic [DREG_W-1:0] rw;
    logic [SREG_W-1:0] rs;
  } entry_t;

  entry_t            ent_q [L];
  entry_t            ent_d [L];
  logic [L-1:0]      valid_q, valid_d;
  logic [L-1:0]      rt_rdy_q, rt_rdy_d;
  logic [L-1:0]      rs_rdy_q, rs_rdy_d;
  logic              hold_q, hold_d;
  logic [IdxW-1:0]   hold_idx_q, hold_idx_d;

  logic [L-1:0]      jump_vec;
  logic [L-1:0]      issuable;
  logic [L-1:0]      rt_hit, rs_hit;
  logic              alloc_rt_hit, alloc_rs_hit;
  logic [IdxW-1:0]   free_idx;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_found;
  logic [IdxW-1:0]   sel_idx;
  logic              alloc_fire, issue_fire;
  entry_t            alloc_ent, issue_ent;

`ifdef BIQ_AGE_SELECT_EN
  logic [IdxW-1:0]   age_q [L];
  logic [IdxW-1:0]   age_d [L];
  logic [IdxW-1:0]   pick_age;
`endif

  always_comb begin
    for (int i = 0; i < L; i++) begin
      jump_vec[i] = ent_q[i].jump;
    end
  end

  assign issuable = valid_q & rt_rdy_q & (jump_vec | rs_rdy_q);

  // Wakeup match for stored entries and for the entry being inserted this cycle.
  always_comb begin
    rt_hit       = '0;
    rs_hit       = '0;
    alloc_rt_hit = 1'b0;
    alloc_rs_hit = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      if (wake_d_valid[k]) begin
        for (int i = 0; i < L; i++) begin
          if (ent_q[i].rt == wake_d_addr[k*DREG_W +: DREG_W]) rt_hit[i] = 1'b1;
        end
        if (alloc_rt_addr == wake_d_addr[k*DREG_W +: DREG_W]) alloc_rt_hit = 1'b1;
      end
      if (wake_s_valid[k]) begin
        for (int i = 0; i < L; i++) begin
          if (ent_q[i].rs == wake_s_addr[k*SREG_W +: SREG_W]) rs_hit[i] = 1'b1;
        end
        if (alloc_rs_addr == wake_s_addr[k*SREG_W +: SREG_W]) alloc_rs_hit = 1'b1;
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < L; i++) begin
      count = count + CntW'(valid_q[i]);
    end
  end

  assign alloc_ready = (count != CntW'(L));

  always_comb begin
    free_idx = '0;
    for (int i = L - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IdxW'(i);
    end
  end

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
`ifdef BIQ_AGE_SELECT_EN
    pick_age   = '0;
    for (int i = 0; i < L; i++) begin
      // Strictly greater keeps the lowest index on equal age.
      if (issuable[i] && (!pick_found || age_q[i] > pick_age)) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(i);
        pick_age   = age_q[i];
      end
    end
`else
    for (int i = 0; i < L; i++) begin
      if (issuable[i] && !pick_found) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(i);
      end
    end
`endif
  end

  // A presented but unaccepted entry stays pinned until the handshake or a flush.
  assign sel_idx     = hold_q ? hold_idx_q : pick_idx;
  assign issue_valid = hold_q ? issuable[hold_idx_q] : pick_found;
  assign issue_fire  = issue_valid & issue_ready & ~flush;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;

  assign issue_ent            = issue_valid ? ent_q[sel_idx] : '0;
  assign issue_rob_addr       = issue_ent.rob;
  assign issue_jump           = issue_ent.jump;
  assign issue_predict_taken  = issue_ent.taken;
  assign issue_pc             = issue_ent.pc;
  assign issue_predict_target = issue_ent.target;
  assign issue_rt_addr        = issue_ent.rt;
  assign issue_rw_addr        = issue_ent.rw;
  assign issue_rs_addr        = issue_ent.rs;

  always_comb begin
    alloc_ent.rob    = alloc_rob_addr;
    alloc_ent.jump   = alloc_jump;
    alloc_ent.taken  = alloc_predict_taken;
    alloc_ent.pc     = alloc_pc;
    alloc_ent.target = alloc_predict_target;
    alloc_ent.rt     = alloc_rt_addr;
    alloc_ent.rw     = alloc_rw_addr;
    alloc_ent.rs     = alloc_rs_addr;
  end

  always_comb begin
    ent_d      = ent_q;
    valid_d    = valid_q;
    rt_rdy_d   = rt_rdy_q | (valid_q & rt_hit);
    rs_rdy_d   = rs_rdy_q | (valid_q & rs_hit);
    hold_d     = hold_q;
    hold_idx_d = hold_idx_q;

    if (issue_fire) begin
      valid_d[sel_idx] = 1'b0;
      hold_d           = 1'b0;
    end else if (issue_valid) begin
      hold_d     = 1'b1;
      hold_idx_d = sel_idx;
    end

    if (alloc_fire) begin
      valid_d[free_idx]  = 1'b1;
      ent_d[free_idx]    = alloc_ent;
      rt_rdy_d[free_idx] = alloc_rt_ready | alloc_rt_hit;
      rs_rdy_d[free_idx] = alloc_rs_ready | alloc_rs_hit;
    end

    if (flush) begin
      valid_d  = '0;
      rt_rdy_d = '0;
      rs_rdy_d = '0;
      hold_d   = 1'b0;
    end
  end

`ifdef BIQ_AGE_SELECT_EN
  always_comb begin
    age_d = age_q;
    if (alloc_fire) begin
      for (int i = 0; i < L; i++) begin
        if (valid_q[i] && age_q[i] != IdxW'(L - 1)) age_d[i] = age_q[i] + 1'b1;
      end
      age_d[free_idx] = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < L; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < L; i++) ent_q[i] <= '0;
      valid_q    <= '0;
      rt_rdy_q   <= '0;
      rs_rdy_q   <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      ent_q      <= ent_d;
      valid_q    <= valid_d;
      rt_rdy_q   <= rt_rdy_d;
      rs_rdy_q   <= rs_rdy_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Bench for branch_issue_queue: directed vectors, literal spot checks and a queue-level model
// compared on every falling edge.
module tb_branch_issue_queue;

  localparam int L        = 8;
  localparam int ROB_W    = 4;
  localparam int PC_W     = 16;
  localparam int DREG_W   = 3;
  localparam int SREG_W   = 2;
  localparam int WB_PORTS = 2;

  logic                       clk = 1'b0;
  logic                       n_rst;
  logic                       alloc_valid, alloc_ready;
  logic [ROB_W-1:0]           alloc_rob_addr;
  logic                       alloc_jump, alloc_predict_taken;
  logic [PC_W-1:0]            alloc_pc, alloc_predict_target;
  logic [DREG_W-1:0]          alloc_rt_addr, alloc_rw_addr;
  logic                       alloc_rt_ready, alloc_rs_ready;
  logic [SREG_W-1:0]          alloc_rs_addr;
  logic [WB_PORTS-1:0]        wake_d_valid, wake_s_valid;
  logic [WB_PORTS*DREG_W-1:0] wake_d_addr;
  logic [WB_PORTS*SREG_W-1:0] wake_s_addr;
  logic                       issue_valid, issue_ready;
  logic [ROB_W-1:0]           issue_rob_addr;
  logic                       issue_jump, issue_predict_taken;
  logic [PC_W-1:0]            issue_pc, issue_predict_target;
  logic [DREG_W-1:0]          issue_rt_addr, issue_rw_addr;
  logic [SREG_W-1:0]          issue_rs_addr;
  logic                       flush;
  logic [$clog2(L):0]         count;

  branch_issue_queue #(
    .L(L), .ROB_W(ROB_W), .PC_W(PC_W), .DREG_W(DREG_W), .SREG_W(SREG_W), .WB_PORTS(WB_PORTS)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_addr(alloc_rob_addr),
    .alloc_jump(alloc_jump), .alloc_predict_taken(alloc_predict_taken), .alloc_pc(alloc_pc),
    .alloc_predict_target(alloc_predict_target), .alloc_rt_addr(alloc_rt_addr),
    .alloc_rt_ready(alloc_rt_ready), .alloc_rw_addr(alloc_rw_addr),
    .alloc_rs_addr(alloc_rs_addr), .alloc_rs_ready(alloc_rs_ready),
    .wake_d_valid(wake_d_valid), .wake_d_addr(wake_d_addr),
    .wake_s_valid(wake_s_valid), .wake_s_addr(wake_s_addr),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rob_addr(issue_rob_addr),
    .issue_jump(issue_jump), .issue_predict_taken(issue_predict_taken), .issue_pc(issue_pc),
    .issue_predict_target(issue_predict_target), .issue_rt_addr(issue_rt_addr),
    .issue_rw_addr(issue_rw_addr), .issue_rs_addr(issue_rs_addr),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Queue model: slots with payload, ready flags and the allocation sequence number.
  typedef struct {
    bit                valid;
    logic [ROB_W-1:0]  rob;
    logic              jump;
    logic              taken;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   tgt;
    logic [DREG_W-1:0] rt;
    logic [DREG_W-1:0] rw;
    logic [SREG_W-1:0] rs;
    bit                rtr;
    bit                rsr;
    int                seq;
  } ment_t;

  ment_t m [L];
  int    m_allocs;
  bit    m_hold;
  int    m_hold_idx;

  function automatic bit d_hit(input logic [DREG_W-1:0] a);
    for (int k = 0; k < WB_PORTS; k++)
      if (wake_d_valid[k] && wake_d_addr[k*DREG_W +: DREG_W] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit s_hit(input logic [SREG_W-1:0] a);
    for (int k = 0; k < WB_PORTS; k++)
      if (wake_s_valid[k] && wake_s_addr[k*SREG_W +: SREG_W] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ready_ent(input int i);
    return m[i].valid && m[i].rtr && (m[i].jump || m[i].rsr);
  endfunction

  int  e_cnt, e_sel, e_free, e_age, e_best;
  bit  e_valid, e_afire, e_ifire;
  logic [63:0] e_fields, a_fields;

  always @(negedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < L; i++) m[i].valid = 1'b0;
      m_hold   = 1'b0;
      m_allocs = 0;
    end
    e_cnt = 0;
    for (int i = 0; i < L; i++) if (m[i].valid) e_cnt++;
    e_valid = 1'b0;
    e_sel   = 0;
    e_best  = -1;
    if (m_hold) begin
      e_valid = 1'b1;
      e_sel   = m_hold_idx;
    end else begin
      for (int i = 0; i < L; i++) begin
        if (ready_ent(i)) begin
`ifdef BIQ_AGE_SELECT_EN
          e_age = m_allocs - m[i].seq - 1;
          if (e_age > L - 1) e_age = L - 1;
          if (!e_valid || e_age > e_best) begin
            e_valid = 1'b1;
            e_sel   = i;
            e_best  = e_age;
          end
`else
          if (!e_valid) begin
            e_valid = 1'b1;
            e_sel   = i;
          end
`endif
        end
      end
    end
    e_fields = e_valid ? 64'({m[e_sel].rob, m[e_sel].jump, m[e_sel].taken, m[e_sel].pc,
                              m[e_sel].tgt, m[e_sel].rt, m[e_sel].rw, m[e_sel].rs}) : 64'd0;
    a_fields = 64'({issue_rob_addr, issue_jump, issue_predict_taken, issue_pc,
                    issue_predict_target, issue_rt_addr, issue_rw_addr, issue_rs_addr});
    check("model_count", 64'(count), 64'(e_cnt));
    check("model_alloc_ready", 64'(alloc_ready), 64'(e_cnt < L));
    check("model_issue_valid", 64'(issue_valid), 64'(e_valid));
    check("model_issue_fields", a_fields, e_fields);

    if (n_rst) begin
      if (flush) begin
        for (int i = 0; i < L; i++) m[i].valid = 1'b0;
        m_hold = 1'b0;
      end else begin
        e_afire = alloc_valid && (e_cnt < L);
        e_ifire = e_valid && issue_ready;
        e_free  = 0;
        for (int i = L - 1; i >= 0; i--) if (!m[i].valid) e_free = i;
        for (int i = 0; i < L; i++) begin
          if (m[i].valid && d_hit(m[i].rt)) m[i].rtr = 1'b1;
          if (m[i].valid && s_hit(m[i].rs)) m[i].rsr = 1'b1;
        end
        if (e_ifire) begin
          m[e_sel].valid = 1'b0;
          m_hold         = 1'b0;
        end else if (e_valid) begin
          m_hold     = 1'b1;
          m_hold_idx = e_sel;
        end
        if (e_afire) begin
          m[e_free].valid = 1'b1;
          m[e_free].rob   = alloc_rob_addr;
          m[e_free].jump  = alloc_jump;
          m[e_free].taken = alloc_predict_taken;
          m[e_free].pc    = alloc_pc;
          m[e_free].tgt   = alloc_predict_target;
          m[e_free].rt    = alloc_rt_addr;
          m[e_free].rw    = alloc_rw_addr;
          m[e_free].rs    = alloc_rs_addr;
          m[e_free].rtr   = alloc_rt_ready || d_hit(alloc_rt_addr);
          m[e_free].rsr   = alloc_rs_ready || s_hit(alloc_rs_addr);
          m[e_free].seq   = m_allocs;
          m_allocs++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid          = 1'b0;
    alloc_rob_addr       = '0;
    alloc_jump           = 1'b0;
    alloc_predict_taken  = 1'b0;
    alloc_pc             = '0;
    alloc_predict_target = '0;
    alloc_rt_addr        = '0;
    alloc_rt_ready       = 1'b0;
    alloc_rw_addr        = '0;
    alloc_rs_addr        = '0;
    alloc_rs_ready       = 1'b0;
    wake_d_valid         = '0;
    wake_d_addr          = '0;
    wake_s_valid         = '0;
    wake_s_addr          = '0;
    flush                = 1'b0;
  endtask

  task automatic set_alloc(input logic [ROB_W-1:0] rob, input logic jump,
                           input logic [PC_W-1:0] pc, input logic [DREG_W-1:0] rt,
                           input logic rtr, input logic [SREG_W-1:0] rs, input logic rsr);
    alloc_valid          = 1'b1;
    alloc_rob_addr       = rob;
    alloc_jump           = jump;
    alloc_predict_taken  = pc[0];
    alloc_pc             = pc;
    alloc_predict_target = ~pc;
    alloc_rt_addr        = rt;
    alloc_rt_ready       = rtr;
    alloc_rw_addr        = ~rt;
    alloc_rs_addr        = rs;
    alloc_rs_ready       = rsr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_rst       = 1'b0;
    issue_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_alloc_ready", 64'(alloc_ready), 64'd1);
    check("reset_count", 64'(count), 64'd0);
    check("reset_issue_pc", 64'(issue_pc), 64'd0);

    // Ready jump issues the cycle after allocation
    tick();
    issue_ready = 1'b1;
    set_alloc(4'd3, 1'b1, 16'h0040, 3'd0, 1'b1, 2'd0, 1'b0);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    check("jump_issue_valid", 64'(issue_valid), 64'd1);
    check("jump_issue_pc", 64'(issue_pc), 64'h0040);
    check("jump_issue_rob", 64'(issue_rob_addr), 64'd3);
    check("jump_count", 64'(count), 64'd1);
    tick();
    @(negedge clk);
    check("jump_count_after", 64'(count), 64'd0);

    // Branch woken by data then status writeback
    set_alloc(4'd7, 1'b0, 16'h0050, 3'd5, 1'b0, 2'd2, 1'b0);
    tick();
    alloc_valid  = 1'b0;
    wake_d_valid = 2'b10;
    wake_d_addr  = {3'd5, 3'd0};
    @(negedge clk);
    check("wake_none_yet", 64'(issue_valid), 64'd0);
    tick();
    wake_d_valid = 2'b00;
    wake_s_valid = 2'b01;
    wake_s_addr  = {2'd0, 2'd2};
    @(negedge clk);
    check("wake_rt_only", 64'(issue_valid), 64'd0);
    tick();
    wake_s_valid = 2'b00;
    @(negedge clk);
    check("wake_both", 64'(issue_valid), 64'd1);
    check("wake_pc", 64'(issue_pc), 64'h0050);
    tick();
    @(negedge clk);
    check("wake_count_after", 64'(count), 64'd0);

    // Insertion bypass: wakeup in the allocation cycle
    set_alloc(4'd9, 1'b1, 16'h0060, 3'd4, 1'b0, 2'd0, 1'b0);
    wake_d_valid = 2'b01;
    wake_d_addr  = {3'd0, 3'd4};
    tick();
    alloc_valid  = 1'b0;
    wake_d_valid = 2'b00;
    @(negedge clk);
    check("bypass_issue_valid", 64'(issue_valid), 64'd1);
    check("bypass_pc", 64'(issue_pc), 64'h0060);
    tick();

    // Fill with issue stalled, then hold stability
    issue_ready = 1'b0;
    for (int i = 0; i < L; i++) begin
      set_alloc(ROB_W'(i), 1'b1, PC_W'(256 + i), 3'd0, 1'b1, 2'd0, 1'b0);
      tick();
    end
    alloc_valid = 1'b0;
    @(negedge clk);
    check("full_count", 64'(count), 64'd8);
    check("full_alloc_ready", 64'(alloc_ready), 64'd0);
    check("full_pc", 64'(issue_pc), 64'h0100);
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      check("hold_pc", 64'(issue_pc), 64'h0100);
      check("hold_valid", 64'(issue_valid), 64'd1);
    end
    tick();
    issue_ready = 1'b1;
    set_alloc(4'hA, 1'b1, 16'h0200, 3'd0, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    check("full_issue_alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    @(negedge clk);
    check("after_issue_count", 64'(count), 64'd7);
    check("after_issue_alloc_ready", 64'(alloc_ready), 64'd1);
    tick();
    issue_ready = 1'b0;
    alloc_valid = 1'b0;
    @(negedge clk);
    check("alloc_issue_count", 64'(count), 64'd7);
`ifdef BIQ_AGE_SELECT_EN
    check("reuse_select_pc", 64'(issue_pc), 64'h0102);
`else
    check("reuse_select_pc", 64'(issue_pc), 64'h0200);
`endif

    // Flush beats simultaneous alloc and issue
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      set_alloc(ROB_W'(i), 1'b1, PC_W'(1024 + i), 3'd0, 1'b1, 2'd0, 1'b0);
      tick();
    end
    set_alloc(4'hF, 1'b1, 16'h04FF, 3'd0, 1'b1, 2'd0, 1'b0);
    flush       = 1'b1;
    issue_ready = 1'b1;
    @(negedge clk);
    check("preflush_count", 64'(count), 64'd5);
    tick();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    issue_ready = 1'b0;
    @(negedge clk);
    check("flush2_count", 64'(count), 64'd0);
    check("flush2_issue_valid", 64'(issue_valid), 64'd0);
    tick();
    @(negedge clk);
    check("flush2_count_later", 64'(count), 64'd0);

    // Older entry in a higher slot versus a newer entry in a reused lower slot
    issue_ready = 1'b1;
    set_alloc(4'd1, 1'b1, 16'h0300, 3'd1, 1'b0, 2'd0, 1'b0);
    tick();
    set_alloc(4'd2, 1'b1, 16'h0301, 3'd2, 1'b0, 2'd0, 1'b0);
    tick();
    alloc_valid  = 1'b0;
    wake_d_valid = 2'b01;
    wake_d_addr  = {3'd0, 3'd1};
    tick();
    wake_d_valid = 2'b00;
    @(negedge clk);
    check("age_a_pc", 64'(issue_pc), 64'h0300);
    tick();
    set_alloc(4'd3, 1'b1, 16'h0302, 3'd3, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    check("age_count", 64'(count), 64'd1);
    tick();
    alloc_valid  = 1'b0;
    issue_ready  = 1'b0;
    wake_d_valid = 2'b11;
    wake_d_addr  = {3'd3, 3'd2};
    tick();
    wake_d_valid = 2'b00;
    @(negedge clk);
`ifdef BIQ_AGE_SELECT_EN
    check("age_select_pc", 64'(issue_pc), 64'h0301);
`else
    check("age_select_pc", 64'(issue_pc), 64'h0302);
`endif
    tick();
    issue_ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset mid-operation
    issue_ready = 1'b0;
    set_alloc(4'd5, 1'b1, 16'h0500, 3'd0, 1'b1, 2'd0, 1'b0);
    tick();
    tick();
    alloc_valid = 1'b0;
    @(negedge clk);
    check("prereset_count", 64'(count), 64'd2);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("async_reset_count", 64'(count), 64'd0);
    check("async_reset_issue_valid", 64'(issue_valid), 64'd0);
    check("async_reset_alloc_ready", 64'(alloc_ready), 64'd1);
    tick();
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_count", 64'(count), 64'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
